// File: rtl/sh4_fpu_fmul_sched_pkg.sv
// Shared types and constants for the SH-4 FPU multiplier issue scheduler:
// operand packing, tag width, requester IDs and ownership-pipe entry layout.
package sh4_fpu_fmul_sched_pkg;

  localparam int FMS_TAG_W = 5;
  localparam int FMS_OP_W  = 36;
  localparam int FMS_CNT_W = 4;

  // Operand bundle layout {sign, exp[8:0], frac[22:0], is_zero, is_inf, is_nan}
  localparam int FMS_SIGN_BIT = 35;
  localparam int FMS_EXP_HI   = 34;
  localparam int FMS_EXP_LO   = 26;
  localparam int FMS_FRAC_HI  = 25;
  localparam int FMS_FRAC_LO  = 3;
  localparam int FMS_ZERO_BIT = 2;
  localparam int FMS_INF_BIT  = 1;
  localparam int FMS_NAN_BIT  = 0;

  localparam logic FMS_PORT_SCALAR = 1'b0;
  localparam logic FMS_PORT_VEC    = 1'b1;

  typedef logic [FMS_TAG_W-1:0] fms_tag_t;
  typedef logic [FMS_OP_W-1:0]  fms_op_t;

  typedef struct packed {
    fms_tag_t tag;
    fms_op_t  a;
    fms_op_t  b;
  } fms_bundle_t;

  typedef struct packed {
    logic live;
    logic owner;
    logic killed;
  } fms_own_t;

  function automatic fms_op_t fms_pack_op(input logic        sign_v,
                                          input logic [8:0]  exp_v,
                                          input logic [22:0] frac_v,
                                          input logic        zero_v,
                                          input logic        inf_v,
                                          input logic        nan_v);
    fms_op_t op;
    op = '0;
    op[FMS_SIGN_BIT]             = sign_v;
    op[FMS_EXP_HI:FMS_EXP_LO]    = exp_v;
    op[FMS_FRAC_HI:FMS_FRAC_LO]  = frac_v;
    op[FMS_ZERO_BIT]             = zero_v;
    op[FMS_INF_BIT]              = inf_v;
    op[FMS_NAN_BIT]              = nan_v;
    return op;
  endfunction

endpackage

// File: rtl/sh4_fpu_fmul_sched_if.sv
// Bus bundle between FPU decode / vector sequencer, the scheduler and the
// multiplier wrapper. The scheduler takes the slave modport.
//
// Request handshake: a request transfers in a cycle where reqN_valid and
// reqN_ready are both high. reqN_ready is combinational from reqN_valid,
// the port's credit and flush; the requester holds tag/a/b stable while
// valid is high and not yet accepted.
interface sh4_fpu_fmul_sched_if;
  import sh4_fpu_fmul_sched_pkg::*;

  logic                 flush;
  logic                 req0_valid;
  logic                 req0_ready;
  fms_tag_t             req0_tag;
  fms_op_t              req0_a;
  fms_op_t              req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  fms_tag_t             req1_tag;
  fms_op_t              req1_a;
  fms_op_t              req1_b;
  logic                 cr0_return;
  logic                 cr1_return;
  logic                 m_valid;
  fms_tag_t             m_tag;
  fms_op_t              m_a;
  fms_op_t              m_b;
  logic                 m_res_valid;
  logic                 resp0_valid;
  logic                 resp1_valid;
  logic                 err;
  logic [FMS_CNT_W-1:0] dbg_credit0;
  logic [FMS_CNT_W-1:0] dbg_credit1;

  modport slave (
    input  flush,
    input  req0_valid, req0_tag, req0_a, req0_b,
    input  req1_valid, req1_tag, req1_a, req1_b,
    input  cr0_return, cr1_return,
    input  m_res_valid,
    output req0_ready, req1_ready,
    output m_valid, m_tag, m_a, m_b,
    output resp0_valid, resp1_valid,
    output err, dbg_credit0, dbg_credit1
  );

  modport master (
    output flush,
    output req0_valid, req0_tag, req0_a, req0_b,
    output req1_valid, req1_tag, req1_a, req1_b,
    output cr0_return, cr1_return,
    output m_res_valid,
    input  req0_ready, req1_ready,
    input  m_valid, m_tag, m_a, m_b,
    input  resp0_valid, resp1_valid,
    input  err, dbg_credit0, dbg_credit1
  );

endinterface

// File: rtl/sh4_fpu_fmul_credit.sv
// Per-requester result-buffer credit counter: net of one take and up to two
// returns per cycle, saturating at CREDITS with a one-cycle overflow flag.
module sh4_fpu_fmul_credit
  import sh4_fpu_fmul_sched_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 take_i,
  input  logic                 ret_a_i,
  input  logic                 ret_b_i,
  output logic [FMS_CNT_W-1:0] credit_o,
  output logic                 avail_o,
  output logic                 ovf_o
);

  localparam int                 SUM_W = FMS_CNT_W + 1;
  localparam logic [SUM_W-1:0]   MAX_C = SUM_W'(CREDITS);

  logic [FMS_CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum;
  logic                 take_ok;

  // A take at zero is never granted upstream; masking it keeps the sum from wrapping.
  assign take_ok = take_i && (cnt_q != '0);

  always_comb begin
    sum   = {1'b0, cnt_q} + SUM_W'(ret_a_i) + SUM_W'(ret_b_i) - SUM_W'(take_ok);
    cnt_d = sum[FMS_CNT_W-1:0];
    ovf_o = 1'b0;
    if (sum > MAX_C) begin
      cnt_d = MAX_C[FMS_CNT_W-1:0];
      ovf_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= MAX_C[FMS_CNT_W-1:0];
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign credit_o = cnt_q;
  assign avail_o  = (cnt_q != '0);

endmodule

// File: rtl/sh4_fpu_fmul_sched.sv
// Shares one pipelined FP multiplier between scalar FMUL (port 0) and the
// FIPR/FTRV sequencer (port 1). FMUL_SCHED_RR_EN selects round-robin arbitration.
module sh4_fpu_fmul_sched
  import sh4_fpu_fmul_sched_pkg::*;
#(
  parameter int LAT     = 3,
  parameter int CREDITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sh4_fpu_fmul_sched_if.slave  bus
);

  logic                 elig0, elig1;
  logic                 grant0, grant1, any_grant;
  logic                 avail0, avail1;
  logic                 ovf0, ovf1;
  logic [FMS_CNT_W-1:0] credit0, credit1;

  logic                 m_valid_q;
  logic                 m_owner_q;
  fms_bundle_t          m_bundle_q, m_bundle_d;

  fms_own_t [LAT-1:0]   pipe_q, pipe_d;
  fms_own_t             tail;
  logic                 tail_kill;
  logic                 auto_ret0, auto_ret1;
  logic                 proto_err;
  logic                 err_q;

  // ---------------------------------------------------------------- arbiter
  assign elig0 = bus.req0_valid && avail0 && !bus.flush;
  assign elig1 = bus.req1_valid && avail1 && !bus.flush;

`ifdef FMUL_SCHED_RR_EN
  logic rr_last_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (rr_last_q == FMS_PORT_SCALAR) grant1 = 1'b1;
      else                              grant0 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  // Reset to the vector port so the scalar port wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= FMS_PORT_VEC;
    end else if (any_grant) begin
      rr_last_q <= grant1 ? FMS_PORT_VEC : FMS_PORT_SCALAR;
    end
  end
`else
  always_comb begin
    grant1 = elig1;
    grant0 = elig0 && !elig1;
  end
`endif

  assign any_grant      = grant0 || grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // ---------------------------------------------------------- issue register
  always_comb begin
    m_bundle_d = '0;
    if (grant1) begin
      m_bundle_d.tag = bus.req1_tag;
      m_bundle_d.a   = bus.req1_a;
      m_bundle_d.b   = bus.req1_b;
    end else begin
      m_bundle_d.tag = bus.req0_tag;
      m_bundle_d.a   = bus.req0_a;
      m_bundle_d.b   = bus.req0_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_owner_q  <= FMS_PORT_SCALAR;
      m_bundle_q <= '0;
    end else begin
      m_valid_q <= any_grant;
      if (any_grant) begin
        m_owner_q  <= grant1 ? FMS_PORT_VEC : FMS_PORT_SCALAR;
        m_bundle_q <= m_bundle_d;
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_tag   = m_bundle_q.tag;
  assign bus.m_a     = m_bundle_q.a;
  assign bus.m_b     = m_bundle_q.b;

  // ---------------------------------------------------------- ownership pipe
  always_comb begin
    pipe_d = pipe_q;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_d[i]        = pipe_q[i-1];
      pipe_d[i].killed = pipe_q[i-1].killed | (bus.flush & pipe_q[i-1].live);
    end
    pipe_d[0].live   = m_valid_q;
    pipe_d[0].owner  = m_owner_q;
    pipe_d[0].killed = bus.flush & m_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // ------------------------------------------------------------ result steer
  // The tail is still in flight during a flush cycle, so flush kills it too.
  assign tail      = pipe_q[LAT-1];
  assign tail_kill = tail.killed | bus.flush;

  assign bus.resp0_valid = tail.live && !tail_kill && (tail.owner == FMS_PORT_SCALAR);
  assign bus.resp1_valid = tail.live && !tail_kill && (tail.owner == FMS_PORT_VEC);
  assign auto_ret0       = tail.live &&  tail_kill && (tail.owner == FMS_PORT_SCALAR);
  assign auto_ret1       = tail.live &&  tail_kill && (tail.owner == FMS_PORT_VEC);
  assign proto_err       = tail.live ^ bus.m_res_valid;

  // ----------------------------------------------------------------- credits
  sh4_fpu_fmul_credit #(.CREDITS(CREDITS)) u_credit0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .take_i   (grant0),
    .ret_a_i  (bus.cr0_return),
    .ret_b_i  (auto_ret0),
    .credit_o (credit0),
    .avail_o  (avail0),
    .ovf_o    (ovf0)
  );

  sh4_fpu_fmul_credit #(.CREDITS(CREDITS)) u_credit1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .take_i   (grant1),
    .ret_a_i  (bus.cr1_return),
    .ret_b_i  (auto_ret1),
    .credit_o (credit1),
    .avail_o  (avail1),
    .ovf_o    (ovf1)
  );

  assign bus.dbg_credit0 = credit0;
  assign bus.dbg_credit1 = credit1;

  // -------------------------------------------------------------- sticky err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | proto_err | ovf0 | ovf1;
    end
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_sh4_fpu_fmul_sched.sv
// Bench for sh4_fpu_fmul_sched: directed phases with random payloads, checked
// against an in-flight-op queue model of arbitration, credits and flush.
module tb_sh4_fpu_fmul_sched;
  import sh4_fpu_fmul_sched_pkg::*;

  localparam int LAT     = 3;
  localparam int CREDITS = 4;

  // ------------------------------------------------------ clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sh4_fpu_fmul_sched_if bus ();

  sh4_fpu_fmul_sched #(.LAT(LAT), .CREDITS(CREDITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ------------------------------------------------------ reference model
  typedef struct {
    int owner;
    bit killed;
    int due;
  } op_t;

  op_t                     inflight[$];
  logic [$bits(fms_bundle_t)-1:0] exp_q[$];
  fms_bundle_t             last_bundle;
  int                      credit_m[2];
`ifdef FMUL_SCHED_RR_EN
  int                      rr_last_m;
`endif
  bit                      err_m;
  bit                      exp_mv;
  int                      cyc;

  int n_vec;
  int n_fail;

  bit       force_tag;
  fms_tag_t forced_tag;
  logic     last_gnt0, last_gnt1, last_resp0, last_resp1, last_mv;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic fms_bundle_t rand_bundle();
    fms_bundle_t b;
    b.tag = fms_tag_t'($urandom);
    b.a   = fms_pack_op(1'($urandom), 9'($urandom), 23'($urandom),
                        $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 7) == 0);
    b.b   = fms_pack_op(1'($urandom), 9'($urandom), 23'($urandom),
                        $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 7) == 0);
    return b;
  endfunction

  task automatic model_reset();
    inflight.delete();
    exp_q.delete();
    last_bundle = '0;
    credit_m[0] = CREDITS;
    credit_m[1] = CREDITS;
`ifdef FMUL_SCHED_RR_EN
    rr_last_m   = 1;
`endif
    err_m       = 1'b0;
    exp_mv      = 1'b0;
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic idle_inputs();
    bus.flush       = 1'b0;
    bus.req0_valid  = 1'b0;
    bus.req0_tag    = '0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_tag    = '0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.cr0_return  = 1'b0;
    bus.cr1_return  = 1'b0;
    bus.m_res_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; cleared outputs are checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_tag", bus.m_tag, 0);
    chk("rst_m_a", bus.m_a, 0);
    chk("rst_m_b", bus.m_b, 0);
    chk("rst_resp0", bus.resp0_valid, 0);
    chk("rst_resp1", bus.resp1_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_credit0", bus.dbg_credit0, CREDITS);
    chk("rst_credit1", bus.dbg_credit1, CREDITS);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs at negedge, check at negedge+1, advance model.
  task automatic drive_cycle(input bit v0, input bit v1, input bit fl,
                             input bit c0, input bit c1, input bit inj);
    bit          due_live, mres, er0, er1, e0, e1;
    int          g, kr0, kr1, nc0, nc1;
    fms_bundle_t b0, b1;
    op_t         op;
    @(negedge clk);
    b0 = rand_bundle();
    b1 = rand_bundle();
    if (force_tag) b0.tag = forced_tag;
    bus.flush      = fl;
    bus.req0_valid = v0;
    bus.req0_tag   = b0.tag;
    bus.req0_a     = b0.a;
    bus.req0_b     = b0.b;
    bus.req1_valid = v1;
    bus.req1_tag   = b1.tag;
    bus.req1_a     = b1.a;
    bus.req1_b     = b1.b;
    bus.cr0_return = c0;
    bus.cr1_return = c1;
    due_live = (inflight.size() != 0) && (inflight[0].due == cyc);
    mres     = due_live || inj;
    bus.m_res_valid = mres;

    if (fl) foreach (inflight[i]) inflight[i].killed = 1'b1;
    er0 = 1'b0; er1 = 1'b0; kr0 = 0; kr1 = 0;
    if (due_live) begin
      if (inflight[0].killed) begin
        if (inflight[0].owner == 0) kr0 = 1; else kr1 = 1;
      end else begin
        if (inflight[0].owner == 0) er0 = 1'b1; else er1 = 1'b1;
      end
    end
    e0 = v0 && (credit_m[0] != 0) && !fl;
    e1 = v1 && (credit_m[1] != 0) && !fl;
    g  = -1;
`ifdef FMUL_SCHED_RR_EN
    if (e0 && e1)  g = (rr_last_m == 0) ? 1 : 0;
    else if (e0)   g = 0;
    else if (e1)   g = 1;
`else
    if (e1)        g = 1;
    else if (e0)   g = 0;
`endif

    #1;
    last_gnt0  = bus.req0_ready;
    last_gnt1  = bus.req1_ready;
    last_resp0 = bus.resp0_valid;
    last_resp1 = bus.resp1_valid;
    last_mv    = bus.m_valid;
    chk("req0_ready", bus.req0_ready, g == 0);
    chk("req1_ready", bus.req1_ready, g == 1);
    chk("resp0_valid", bus.resp0_valid, er0);
    chk("resp1_valid", bus.resp1_valid, er1);
    chk("m_valid", bus.m_valid, exp_mv);
    if (exp_mv && exp_q.size() != 0) last_bundle = exp_q.pop_front();
    chk("m_tag", bus.m_tag, last_bundle.tag);
    chk("m_a", bus.m_a, last_bundle.a);
    chk("m_b", bus.m_b, last_bundle.b);
    chk("err", bus.err, err_m);
    chk("credit0", bus.dbg_credit0, credit_m[0]);
    chk("credit1", bus.dbg_credit1, credit_m[1]);

    nc0 = credit_m[0] + int'(c0) + kr0 - ((g == 0) ? 1 : 0);
    nc1 = credit_m[1] + int'(c1) + kr1 - ((g == 1) ? 1 : 0);
    if (nc0 > CREDITS) begin nc0 = CREDITS; err_m = 1'b1; end
    if (nc1 > CREDITS) begin nc1 = CREDITS; err_m = 1'b1; end
    credit_m[0] = nc0;
    credit_m[1] = nc1;
    if (due_live != mres) err_m = 1'b1;
    if (due_live) void'(inflight.pop_front());
    if (g >= 0) begin
      op.owner  = g;
      op.killed = 1'b0;
      op.due    = cyc + 1 + LAT;
      inflight.push_back(op);
      exp_q.push_back((g == 1) ? b1 : b0);
`ifdef FMUL_SCHED_RR_EN
      rr_last_m = g;
`endif
      exp_mv = 1'b1;
    end else begin
      exp_mv = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  (credit_m[0] < CREDITS) && ($urandom_range(0, 2) == 0),
                  (credit_m[1] < CREDITS) && ($urandom_range(0, 2) == 0),
                  1'b0);
    end
  endtask

  // ------------------------------------------------------ directed sequence
  int gcount;
  int rcount;

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    cyc       = 0;
    force_tag = 1'b0;
    forced_tag = '0;
    idle_inputs();
    model_reset();

    // Single issue: grant at cycle 0, m_valid at 1, resp0 at 1+LAT.
    do_reset();
    force_tag  = 1'b1;
    forced_tag = 5'h05;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    force_tag  = 1'b0;
    chk("single_ready0", last_gnt0, 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_m_valid", last_mv, 1);
    chk("single_m_tag", bus.m_tag, 5'h05);
    idle_cycles(LAT - 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_resp0", last_resp0, 1);
    chk("single_resp1", last_resp1, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_resp0_done", last_resp0, 0);

    // Contention: alternating grants with round-robin, port 1 always otherwise.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FMUL_SCHED_RR_EN
      chk("contend_gnt1", last_gnt1, (i % 2) == 1);
      chk("contend_gnt0", last_gnt0, (i % 2) == 0);
`else
      chk("contend_gnt1", last_gnt1, 1);
      chk("contend_gnt0", last_gnt0, 0);
`endif
    end

    // Credit exhaustion on port 0; a single return allows one more grant.
    do_reset();
    gcount = 0;
    repeat (6) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      gcount += int'(last_gnt0);
    end
    chk("exhaust_grants", gcount, CREDITS);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("exhaust_return_cycle", last_gnt0, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exhaust_regrant", last_gnt0, 1);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exhaust_port0_blocked", last_gnt0, 0);
    chk("exhaust_port1_free", last_gnt1, 1);

    // Flush with three ops in flight: no responses, credits restored.
    do_reset();
    rcount = 0;
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_no_grant0", last_gnt0, 0);
    chk("flush_no_grant1", last_gnt1, 0);
    rcount += int'(last_resp0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_next_grant", last_gnt1, 1);
    rcount += int'(last_resp0);
    repeat (LAT + 2) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rcount += int'(last_resp0);
    end
    chk("flush_resp0_count", rcount, 0);
    chk("flush_credit0", bus.dbg_credit0, CREDITS);
    chk("flush_credit1", bus.dbg_credit1, CREDITS - 1);

    // Simultaneous grant and return; return at full credit.
    do_reset();
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("simul_credit_pre", bus.dbg_credit0, 2);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("simul_grant", last_gnt0, 1);
    settle();
    chk("simul_credit_net", bus.dbg_credit0, 2);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("simul_credit_full", bus.dbg_credit0, CREDITS);
    chk("simul_err_clear", bus.err, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("simul_credit_sat", bus.dbg_credit0, CREDITS);
    chk("simul_err_ovf", bus.err, 1);

    // Protocol error: result with an empty pipe, sticky until async reset.
    do_reset();
    idle_cycles(LAT + 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("proto_err_set", bus.err, 1);
    rand_cycles(20);
    chk("proto_err_sticky", bus.err, 1);
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("proto_err_cleared", bus.err, 0);

    // Random traffic with an asynchronous reset in the middle.
    rand_cycles(150);
    do_reset();
    rand_cycles(150);
    idle_cycles(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
